// File: rtl/hvmux_seq.sv
// hvmux_seq -- switch-pattern sequencer feeding the hvmuxctl SPI controller.
//
// A small register table of SWITCH_N-bit patterns is written by the host.
// Each trig sends the entry at seq_idx to hvmuxctl through its din/dvalid/busy
// handshake. ready pulses once the pattern is latched and, optionally, settled.
// seq_idx wraps at the programmed sequence length.
//
// Optional feature macro: HVMUX_SEQ_SETTLE_EN
//   defined   : a SETTLE state counts SETTLE_CYC cycles after the mux goes idle
//   undefined : ready pulses as soon as the mux goes idle (SETTLE_CYC ignored)
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   cfg_wr        : table write strobe
//   cfg_addr      : table write address
//   cfg_data      : table write data
//   cfg_len       : active sequence length (0 -> 1, >DEPTH -> DEPTH)
//   rewind        : forces seq_idx to 0
//   trig          : starts transfer of the next pattern
//   mux_din       : pattern to hvmuxctl.din (held until the next send)
//   mux_dvalid    : one-cycle strobe to hvmuxctl.dvalid
//   mux_busy      : hvmuxctl.busy
//   busy          : sequencer not idle
//   ready         : one-cycle pulse, pattern latched and settled
//   overrun       : one-cycle pulse, trig arrived while busy
//   seq_idx       : index of the next entry to send
module hvmux_seq #(
  parameter int unsigned SWITCH_N   = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned BUSY_TO    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [SWITCH_N-1:0] cfg_data,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic                rewind,
  input  logic                trig,
  output logic [SWITCH_N-1:0] mux_din,
  output logic                mux_dvalid,
  input  logic                mux_busy,
  output logic                busy,
  output logic                ready,
  output logic                overrun,
  output logic [ADDR_W-1:0]   seq_idx
);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
      SETTLE_CYC < 1 || SETTLE_CYC > 65535 || BUSY_TO < 1 || BUSY_TO > 65535) begin : g_param_check
    $error("hvmux_seq: illegal parameter set");
  end

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     TO_LAST = 16'(BUSY_TO - 1);

`ifdef HVMUX_SEQ_SETTLE_EN
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_SETTLE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [SWITCH_N-1:0] tbl [DEPTH];
  logic [ADDR_W:0]     eff_len;
  logic [15:0]         to_cnt;
  logic                ready_set;
  logic                accept;
  // Remembers a rewind that coincided with the accepted trig, so the advance
  // in SEND lands on 0 instead of 1.
  logic                rew_pend;

`ifdef HVMUX_SEQ_SETTLE_EN
  logic [15:0]         settle_cnt;
`endif

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && trig;

  always_comb begin
    if (cfg_len == '0) begin
      eff_len = (ADDR_W+1)'(1);
    end else if (cfg_len > LEN_MAX) begin
      eff_len = LEN_MAX;
    end else begin
      eff_len = cfg_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A controller that never raises busy is assumed to have taken the
        // pattern once the timeout expires.
        if (mux_busy || (to_cnt == TO_LAST)) begin
          state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!mux_busy) begin
`ifdef HVMUX_SEQ_SETTLE_EN
          state_nxt = S_SETTLE;
`else
          state_nxt = S_IDLE;
          ready_set = 1'b1;
`endif
        end
      end
`ifdef HVMUX_SEQ_SETTLE_EN
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = S_IDLE;
          ready_set = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl        <= '{default: '0};
      mux_din    <= '0;
      mux_dvalid <= 1'b0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
      seq_idx    <= '0;
      to_cnt     <= '0;
      rew_pend   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        tbl[cfg_addr] <= cfg_data;
      end

      // Captured here so later table writes never disturb the pattern in flight.
      if (accept) begin
        mux_din <= tbl[seq_idx];
      end
      mux_dvalid <= accept;
      ready      <= ready_set;
      overrun    <= trig && (state != S_IDLE);

      if (state == S_WAIT_BUSY) begin
        to_cnt <= to_cnt + 16'd1;
      end else begin
        to_cnt <= '0;
      end

      if (accept) begin
        rew_pend <= rewind;
      end else if (state == S_SEND) begin
        rew_pend <= 1'b0;
      end

      if (state == S_SEND) begin
        if (rewind || rew_pend) begin
          seq_idx <= '0;
        end else if ({1'b0, seq_idx} >= (eff_len - 1'b1)) begin
          seq_idx <= '0;
        end else begin
          seq_idx <= seq_idx + 1'b1;
        end
      end else if (rewind) begin
        seq_idx <= '0;
      end
    end
  end

`ifdef HVMUX_SEQ_SETTLE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt + 16'd1;
    end else begin
      settle_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_hvmux_seq.sv
// tb_hvmux_seq -- self-checking bench for hvmux_seq.
// A behavioural hvmuxctl/max14866 stand-in answers the handshake and records
// every latched pattern; a table/index reference model predicts what is sent.
module tb_hvmux_seq;

  localparam int SW   = 16;
  localparam int DEP  = 8;
  localparam int AW   = 3;
  localparam int STL  = 10;
  localparam int BTO  = 4;
`ifdef HVMUX_SEQ_SETTLE_EN
  localparam int SETTLE_LAT = STL;
`else
  localparam int SETTLE_LAT = 0;
`endif

  logic          tb_clk;
  logic          rst;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_data;
  logic [AW:0]   cfg_len;
  logic          rewind;
  logic          trig;
  logic [SW-1:0] mux_din;
  logic          mux_dvalid;
  logic          mux_busy;
  logic          busy;
  logic          ready;
  logic          overrun;
  logic [AW-1:0] seq_idx;

  hvmux_seq #(
    .SWITCH_N  (SW),
    .DEPTH     (DEP),
    .SETTLE_CYC(STL),
    .BUSY_TO   (BTO)
  ) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_len   (cfg_len),
    .rewind    (rewind),
    .trig      (trig),
    .mux_din   (mux_din),
    .mux_dvalid(mux_dvalid),
    .mux_busy  (mux_busy),
    .busy      (busy),
    .ready     (ready),
    .overrun   (overrun),
    .seq_idx   (seq_idx)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  // Reference model state
  logic [SW-1:0] ref_tbl [DEP];
  int            ref_idx;
  int            ref_len;

  // Mux controller stand-in
  int            busy_dly  = 1;
  int            xfer_len  = 3;
  bit            spi_dead  = 1'b0;
  int            fall_cyc  = 0;
  int            fall_cnt  = 0;
  logic [SW-1:0] latched [$];

  initial begin
    logic [SW-1:0] pat;
    mux_busy = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (mux_dvalid === 1'b1 && !spi_dead) begin
        pat = mux_din;
        repeat (busy_dly) @(posedge tb_clk);
        #2 mux_busy = 1'b1;
        repeat (xfer_len) @(posedge tb_clk);
        #2 mux_busy = 1'b0;
        fall_cyc = cyc;
        fall_cnt = fall_cnt + 1;
        latched.push_back(pat);
      end
    end
  end

  // Pulse counters and mux_din stability watch
  int            dv_cnt     = 0;
  int            ov_cnt     = 0;
  int            din_glitch = 0;
  logic [SW-1:0] prev_din;
  logic          prev_rst   = 1'b1;

  always @(negedge tb_clk) begin
    if (mux_dvalid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (!rst && !prev_rst && mux_dvalid !== 1'b1 && mux_din !== prev_din)
      din_glitch <= din_glitch + 1;
    prev_din <= mux_din;
    prev_rst <= rst;
  end

  initial begin
    #3000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [SW-1:0] data);
    cfg_wr   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = data;
    tick();
    cfg_wr   = 1'b0;
    ref_tbl[addr] = data;
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    ref_idx = 0;
    chk("rewind_idx", 32'(seq_idx), 0);
  endtask

  // mode 0: plain, 1: rewrite the in-flight entry, 2: trig during WAIT_IDLE
  task automatic do_txn(input bit rw, input int mode);
    int            e_len;
    int            sent;
    logic [SW-1:0] exp;
    int            tcyc;
    int            n0;
    bit            seen;
    logic [SW-1:0] wd;
    e_len = (ref_len == 0) ? 1 : ((ref_len > DEP) ? DEP : ref_len);
    sent  = ref_idx;
    exp   = ref_tbl[sent];
    if (rw) ref_idx = 0;
    else    ref_idx = (ref_idx + 1 >= e_len) ? 0 : ref_idx + 1;
    n0 = dv_cnt;

    trig   = 1'b1;
    rewind = rw;
    tick();
    trig   = 1'b0;
    rewind = 1'b0;
    tcyc   = cyc;
    chk("dvalid_on", 32'(mux_dvalid), 1);
    chk("din_sent", 32'(mux_din), 32'(exp));
    chk("busy_on", 32'(busy), 1);

    if (mode == 1) begin
      wd = SW'($urandom);
      cfg_write(sent, wd);
      chk("din_hold", 32'(mux_din), 32'(exp));
    end else if (mode == 2) begin
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        if (mux_busy === 1'b1) seen = 1'b1;
        else tick();
      end
      chk("mux_busy_rise", 32'(seen), 1);
      tick();
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("overrun_on", 32'(overrun), 1);
      tick();
      chk("overrun_off", 32'(overrun), 0);
    end

    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (ready === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("ready_seen", 32'(seen), 1);
    chk("busy_off", 32'(busy), 0);
    chk("seq_idx", 32'(seq_idx), 32'(ref_idx));
    chk("dvalid_cycles", 32'(dv_cnt - n0), 1);
    if (!spi_dead) begin
      chk("latch_cnt", 32'(latched.size()), 1);
      if (latched.size() > 0) chk("latch_val", 32'(latched.pop_front()), 32'(exp));
      chk("settle_lat", 32'(cyc - fall_cyc), 32'(1 + SETTLE_LAT));
    end else begin
      chk("timeout_lat", 32'(cyc - tcyc), 32'(1 + BTO + 1 + SETTLE_LAT));
    end
  endtask

  initial begin
    int f0;
    bit seen;
    rst      = 1'b1;
    trig     = 1'b0;
    rewind   = 1'b0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_len  = '0;
    for (int i = 0; i < DEP; i++) ref_tbl[i] = '0;
    ref_idx = 0;
    ref_len = 0;

    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_din", 32'(mux_din), 0);
    chk("rst_dvalid", 32'(mux_dvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_idx", 32'(seq_idx), 0);
    rst = 1'b0;
    tick();

    // Basic trigger
    cfg_write(0, 16'hFFFF);
    cfg_write(1, 16'h5555);
    cfg_write(2, 16'hAAAA);
    for (int a = 3; a < DEP; a++) cfg_write(a, SW'($urandom));
    cfg_len = 4'd3;
    ref_len = 3;
    repeat (3) do_txn(1'b0, 0);

    // Wrap-around with length 0
    cfg_len = 4'd0;
    ref_len = 0;
    do_rewind();
    repeat (4) do_txn(1'b0, 0);

    // Overrun during WAIT_IDLE
    cfg_len  = 4'd3;
    ref_len  = 3;
    xfer_len = 8;
    do_txn(1'b0, 2);
    xfer_len = 3;

    // Rewind coinciding with trig
    do_rewind();
    do_txn(1'b0, 0);
    do_txn(1'b0, 0);
    chk("idx_before_rw", 32'(seq_idx), 2);
    do_txn(1'b1, 0);

    // Randomized traffic
    for (int it = 0; it < 14; it++) begin
      ref_len  = int'($urandom_range(0, 15));
      cfg_len  = 4'(ref_len);
      busy_dly = int'($urandom_range(1, 3));
      xfer_len = int'($urandom_range(1, 6));
      if ($urandom_range(0, 2) == 0)
        cfg_write(int'($urandom_range(0, DEP - 1)), SW'($urandom));
      do_txn($urandom_range(0, 3) == 0, int'($urandom_range(0, 1)));
    end

    // Busy timeout
    busy_dly = 1;
    xfer_len = 3;
    spi_dead = 1'b1;
    do_txn(1'b0, 0);
    spi_dead = 1'b0;

    // Reset after the mux has gone idle (inside SETTLE when built in)
    xfer_len = 2;
    f0 = fall_cnt;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (fall_cnt != f0) seen = 1'b1;
      else tick();
    end
    chk("rst_test_fall", 32'(seen), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_idx", 32'(seq_idx), 0);
    chk("midrst_din", 32'(mux_din), 0);
    chk("midrst_dvalid", 32'(mux_dvalid), 0);
    rst = 1'b0;
    latched.delete();
    for (int i = 0; i < DEP; i++) ref_tbl[i] = '0;
    ref_idx = 0;
    tick();

    // Table was cleared by reset
    do_txn(1'b0, 0);

    chk("din_stable", 32'(din_glitch), 0);
    chk("overrun_pulses", 32'(ov_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
